block_grid: RTL and testbench

BLOCK_GRID -- requirements
Module: block_grid

---
 rtl/block_grid.sv | 156 +++++++++++++++
 tb/tb_block_grid.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/block_grid.sv
// Breakout-style block grid: per-row block bitmap with display row pointer, collision
// hit/acknowledge port and block counter. Optional score counter under BLOCK_GRID_SCORE_EN.
module block_grid #(
    parameter int unsigned NUM_ROWS  = 16,
    parameter int unsigned NUM_COLS  = 13,
    parameter int unsigned INIT_MODE = 1,
    // Index widths stay at least one bit so a single-column grid still has a legal port
    localparam int unsigned RowW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
    localparam int unsigned ColW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1,
    localparam int unsigned CntW = $clog2(NUM_ROWS * NUM_COLS + 1)
) (
    input  logic                clk,
    input  logic                nRst,
    input  logic                frame_start,
    input  logic                next_line,
    output logic [NUM_COLS-1:0] line,
    output logic [RowW-1:0]     row_idx,
    input  logic                hit_valid,
    input  logic [RowW-1:0]     hit_row,
    input  logic [ColW-1:0]     hit_col,
    output logic                hit_done,
    output logic                hit_was_block,
    input  logic                reload,
    output logic [CntW-1:0]     blocks_left,
    output logic                level_clear
`ifdef BLOCK_GRID_SCORE_EN
    ,
    output logic [15:0]         score
`endif
);

    function automatic logic [NUM_COLS-1:0] init_row(input int unsigned r);
        logic [NUM_COLS-1:0] row;
        row = '0;
        for (int unsigned c = 0; c < NUM_COLS; c++) begin
            row[c] = (INIT_MODE == 0) ? 1'b1 : (((r + c) % 2) == 0);
        end
        return row;
    endfunction

    // Exact population of the initial pattern, so odd dimensions are counted correctly
    function automatic int unsigned init_count();
        int unsigned n;
        n = 0;
        for (int unsigned r = 0; r < NUM_ROWS; r++) begin
            for (int unsigned c = 0; c < NUM_COLS; c++) begin
                if ((INIT_MODE == 0) || (((r + c) % 2) == 0)) begin
                    n++;
                end
            end
        end
        return n;
    endfunction

    localparam int unsigned InitCount = init_count();

    logic [NUM_COLS-1:0] grid_q [NUM_ROWS];
    logic [NUM_COLS-1:0] grid_d [NUM_ROWS];
    logic [RowW-1:0]     row_idx_q, row_idx_d;
    logic [CntW-1:0]     blocks_q, blocks_d;
    logic                hit_done_q, hit_done_d;
    logic                hit_was_q, hit_was_d;
    logic                in_range;
    logic                hit_bit;
    logic                hit_take;

`ifdef BLOCK_GRID_SCORE_EN
    logic [15:0] score_q, score_d;
    logic [16:0] score_sum;
`endif

    always_comb begin
        in_range = (32'(hit_row) < NUM_ROWS) && (32'(hit_col) < NUM_COLS);
        hit_bit  = 1'b0;
        if (in_range) begin
            hit_bit = grid_q[hit_row][hit_col];
        end
        hit_take = hit_valid && !reload && in_range && hit_bit && (blocks_q != '0);
    end

    always_comb begin
        grid_d     = grid_q;
        row_idx_d  = row_idx_q;
        blocks_d   = blocks_q;
        hit_done_d = hit_valid;
        hit_was_d  = 1'b0;

        if (reload) begin
            for (int unsigned r = 0; r < NUM_ROWS; r++) begin
                grid_d[r] = init_row(r);
            end
            row_idx_d = '0;
            blocks_d  = CntW'(InitCount);
        end else begin
            if (frame_start) begin
                row_idx_d = '0;
            end else if (next_line) begin
                row_idx_d = (row_idx_q == RowW'(NUM_ROWS - 1)) ? '0 : row_idx_q + RowW'(1);
            end
            if (hit_take) begin
                grid_d[hit_row][hit_col] = 1'b0;
                blocks_d                 = blocks_q - CntW'(1);
                hit_was_d                = 1'b1;
            end
        end
    end

`ifdef BLOCK_GRID_SCORE_EN
    // Upper rows are worth more: NUM_ROWS - hit_row points, saturating at 16'hFFFF
    always_comb begin
        score_sum = {1'b0, score_q} + (17'(NUM_ROWS) - 17'(hit_row));
        score_d   = score_q;
        if (hit_take) begin
            score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            score_q <= '0;
        end else begin
            score_q <= score_d;
        end
    end

    assign score = score_q;
`endif

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            for (int unsigned r = 0; r < NUM_ROWS; r++) begin
                grid_q[r] <= init_row(r);
            end
            row_idx_q  <= '0;
            blocks_q   <= CntW'(InitCount);
            hit_done_q <= 1'b0;
            hit_was_q  <= 1'b0;
        end else begin
            for (int unsigned r = 0; r < NUM_ROWS; r++) begin
                grid_q[r] <= grid_d[r];
            end
            row_idx_q  <= row_idx_d;
            blocks_q   <= blocks_d;
            hit_done_q <= hit_done_d;
            hit_was_q  <= hit_was_d;
        end
    end

    assign line          = grid_q[row_idx_q];
    assign row_idx       = row_idx_q;
    assign hit_done      = hit_done_q;
    assign hit_was_block = hit_was_q;
    assign blocks_left   = blocks_q;
    assign level_clear   = (blocks_q == '0);

endmodule

// File: tb/tb_block_grid.sv
// Directed, table-driven bench for block_grid at default parameters (16x13, checkerboard).
// Score checks are included when BLOCK_GRID_SCORE_EN is defined.
module tb_block_grid;

    logic        clk = 1'b0;
    logic        nRst;
    logic        frame_start, next_line, hit_valid, reload;
    logic [3:0]  hit_row, hit_col;
    logic [12:0] line;
    logic [3:0]  row_idx;
    logic        hit_done, hit_was_block, level_clear;
    logic [7:0]  blocks_left;
`ifdef BLOCK_GRID_SCORE_EN
    logic [15:0] score;
`endif

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    block_grid dut (
        .clk           (clk),
        .nRst          (nRst),
        .frame_start   (frame_start),
        .next_line     (next_line),
        .line          (line),
        .row_idx       (row_idx),
        .hit_valid     (hit_valid),
        .hit_row       (hit_row),
        .hit_col       (hit_col),
        .hit_done      (hit_done),
        .hit_was_block (hit_was_block),
        .reload        (reload),
        .blocks_left   (blocks_left),
        .level_clear   (level_clear)
`ifdef BLOCK_GRID_SCORE_EN
        ,
        .score         (score)
`endif
    );

    typedef struct {
        logic        fs, nl, hv, rl;
        logic [3:0]  hr, hc;
        logic [12:0] e_line;
        logic [3:0]  e_row;
        logic        e_done, e_was;
        logic [7:0]  e_left;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic fs, logic nl, logic hv, logic [3:0] hr, logic [3:0] hc,
                                logic rl, logic [12:0] e_line, logic [3:0] e_row,
                                logic e_done, logic e_was, logic [7:0] e_left);
        vec_t v;
        v.fs = fs; v.nl = nl; v.hv = hv; v.hr = hr; v.hc = hc; v.rl = rl;
        v.e_line = e_line; v.e_row = e_row; v.e_done = e_done; v.e_was = e_was;
        v.e_left = e_left;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic fs, input logic nl, input logic hv, input logic [3:0] hr,
                         input logic [3:0] hc, input logic rl);
        frame_start = fs; next_line = nl; hit_valid = hv; hit_row = hr; hit_col = hc;
        reload = rl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          was_cnt;
        logic [3:0]  r;
        drive(0, 0, 0, 0, 0, 0);
        nRst = 1'b0;

        // Row 0 of the checkerboard: columns 0,2,..,12 present
        #12;
        check("rst_line", 32'(line), 32'h1555);
        check("rst_row", 32'(row_idx), 0);
        check("rst_left", 32'(blocks_left), 104);
        check("rst_clear", 32'(level_clear), 0);
        check("rst_done", 32'(hit_done), 0);
        check("rst_was", 32'(hit_was_block), 0);
        @(negedge clk);
        nRst = 1'b1;

        for (int i = 1; i <= 16; i++) begin
            r = 4'(i % 16);
            vecs.push_back(mk(0, 1, 0, 0, 0, 0, r[0] ? 13'h0AAA : 13'h1555, r, 0, 0, 104));
        end
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 13'h0AAA, 1, 0, 0, 104));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 13'h1555, 0, 0, 0, 104));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 13'h1554, 0, 1, 1, 103));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 13'h1554, 0, 1, 0, 103));
        vecs.push_back(mk(0, 0, 1, 0, 13, 0, 13'h1554, 0, 1, 0, 103));
        vecs.push_back(mk(0, 0, 1, 0, 1, 0, 13'h1554, 0, 1, 0, 103));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 13'h1554, 0, 0, 0, 103));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 13'h0AAA, 1, 0, 0, 103));
        // Step onto row 2 and hit (2,4) at the same edge: cleared bit visible right away
        vecs.push_back(mk(0, 1, 1, 2, 4, 0, 13'h1545, 2, 1, 1, 102));
        vecs.push_back(mk(0, 0, 1, 2, 4, 0, 13'h1545, 2, 1, 0, 102));
        vecs.push_back(mk(0, 0, 1, 15, 15, 0, 13'h1545, 2, 1, 0, 102));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 13'h1554, 0, 0, 0, 102));
        vecs.push_back(mk(0, 1, 1, 1, 1, 1, 13'h1555, 0, 1, 0, 104));

        foreach (vecs[i]) begin
            drive(vecs[i].fs, vecs[i].nl, vecs[i].hv, vecs[i].hr, vecs[i].hc, vecs[i].rl);
            tick();
            check($sformatf("v%0d_line", i), 32'(line), 32'(vecs[i].e_line));
            check($sformatf("v%0d_row", i), 32'(row_idx), 32'(vecs[i].e_row));
            check($sformatf("v%0d_done", i), 32'(hit_done), 32'(vecs[i].e_done));
            check($sformatf("v%0d_was", i), 32'(hit_was_block), 32'(vecs[i].e_was));
            check($sformatf("v%0d_left", i), 32'(blocks_left), 32'(vecs[i].e_left));
            check($sformatf("v%0d_clear", i), 32'(level_clear), 32'(vecs[i].e_left == 0));
        end

        // Clear the whole level, one hit per present block
        was_cnt = 0;
        for (int rr = 0; rr < 16; rr++) begin
            for (int cc = 0; cc < 13; cc++) begin
                if (((rr + cc) % 2) == 0) begin
                    drive(0, 0, 1, 4'(rr), 4'(cc), 0);
                    tick();
                    if (hit_was_block === 1'b1) was_cnt++;
                end
            end
        end
        drive(0, 0, 0, 0, 0, 0);
        check("clr_was_cnt", 32'(was_cnt), 104);
        check("clr_left", 32'(blocks_left), 0);
        check("clr_level", 32'(level_clear), 1);
        check("clr_line", 32'(line), 0);
        drive(0, 0, 1, 0, 0, 0);
        tick();
        check("clr_nounder", 32'(blocks_left), 0);
        check("clr_nowas", 32'(hit_was_block), 0);
        drive(0, 1, 0, 0, 0, 0);
        tick();
        tick();
        check("clr_row2", 32'(row_idx), 2);

        drive(0, 1, 1, 0, 0, 1);
        tick();
        check("rl_left", 32'(blocks_left), 104);
        check("rl_level", 32'(level_clear), 0);
        check("rl_done", 32'(hit_done), 1);
        check("rl_was", 32'(hit_was_block), 0);
        check("rl_row", 32'(row_idx), 0);
        check("rl_line", 32'(line), 32'h1555);

        // Reset asserted while an acknowledge is outstanding
        drive(0, 0, 1, 0, 0, 0);
        tick();
        check("mh_done_pre", 32'(hit_done), 1);
        check("mh_left_pre", 32'(blocks_left), 103);
        drive(0, 0, 0, 0, 0, 0);
        nRst = 1'b0;
        #1;
        check("mh_done", 32'(hit_done), 0);
        check("mh_was", 32'(hit_was_block), 0);
        check("mh_left", 32'(blocks_left), 104);
        check("mh_line", 32'(line), 32'h1555);
        @(negedge clk);
        nRst = 1'b1;

`ifdef BLOCK_GRID_SCORE_EN
        check("sc_rst", 32'(score), 0);
        drive(0, 0, 1, 0, 0, 0);
        tick();
        check("sc_hit0", 32'(score), 16);
        drive(0, 0, 1, 15, 1, 0);
        tick();
        check("sc_hit15", 32'(score), 17);
        drive(0, 0, 1, 15, 1, 0);
        tick();
        check("sc_rehit", 32'(score), 17);
        drive(0, 0, 0, 0, 0, 1);
        tick();
        check("sc_reload", 32'(score), 17);
        drive(0, 0, 0, 0, 0, 0);
        nRst = 1'b0;
        #1;
        check("sc_nrst", 32'(score), 0);
        @(negedge clk);
        nRst = 1'b1;
`endif

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
